// File: rtl/rom_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_access_ctrl_pkg
// Purpose  : Shared definitions for the instruction-ROM access controller:
//            controller state encodings, default ROM geometry and byte-lane
//            layout of a ROM word.
// Revision : 1.0 - initial release
// ============================================================================
package rom_access_ctrl_pkg;

    // Default word-address width of the ROM (1024 x 32-bit words)
    localparam int ROM_AW_DEF = 10;

    // Controller state encoding
    localparam int         STATE_W = 1;
    localparam logic [0:0] ST_BOOT = 1'b0;  // only the loader may touch the ROM
    localparam logic [0:0] ST_RUN  = 1'b1;  // fetch/load arbitration active

    // Byte-lane layout of a 32-bit ROM word; lane k covers bits [8k+7:8k]
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

endpackage : rom_access_ctrl_pkg
`default_nettype wire

// File: rtl/rom_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_access_ctrl_if
// Purpose  : Bundles the IF-stage fetch port, the boot-loader write port and
//            the ROM array port of the ROM access controller.
//            slave  : controller view
//            master : requester / ROM-array view
// Revision : 1.0 - initial release
// ============================================================================
interface rom_access_ctrl_if #(
    parameter int ROM_AW = 10
);
    // Fetch port
    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_valid_o;
    logic [31:0]       fetch_data_o;
    logic              fetch_err_o;
    // Loader port
    logic              load_req_i;
    logic [31:0]       load_addr_i;
    logic [31:0]       load_data_i;
    logic [3:0]        load_be_i;
    logic              load_last_i;
    logic              load_ack_o;
    logic              boot_done_o;
    // ROM array port
    logic [ROM_AW-1:0] rom_addr_o;
    logic              rom_re_o;
    logic [3:0]        rom_we_o;
    logic [31:0]       rom_wdata_o;
    logic [31:0]       rom_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        output fetch_gnt_o, fetch_valid_o, fetch_data_o, fetch_err_o,
        input  load_req_i, load_addr_i, load_data_i, load_be_i, load_last_i,
        output load_ack_o, boot_done_o,
        output rom_addr_o, rom_re_o, rom_we_o, rom_wdata_o,
        input  rom_rdata_i
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        input  fetch_gnt_o, fetch_valid_o, fetch_data_o, fetch_err_o,
        output load_req_i, load_addr_i, load_data_i, load_be_i, load_last_i,
        input  load_ack_o, boot_done_o,
        input  rom_addr_o, rom_re_o, rom_we_o, rom_wdata_o,
        output rom_rdata_i
    );
endinterface : rom_access_ctrl_if
`default_nettype wire

// File: rtl/rom_access_ctrl_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : rom_addr_check
// Purpose  : Combinational decoder of a byte address against the ROM window.
// Ports    : i_addr     - byte address
//            o_in_range - ROM_BASE <= addr < ROM_BASE + 4*2**ROM_AW (no wrap)
//            o_aligned  - addr[1:0] == 0
//            o_word_idx - (addr - ROM_BASE) >> 2, truncated to ROM_AW bits
// Revision : 1.0 - initial release
// ============================================================================
module rom_addr_check #(
    parameter int          ROM_AW   = 10,
    parameter logic [31:0] ROM_BASE = 32'h0000_0000
) (
    input  wire logic [31:0]       i_addr,
    output logic                   o_in_range,
    output logic                   o_aligned,
    output logic [ROM_AW-1:0]      o_word_idx
);
    // Window size in bytes, held in 33 bits so a full 4 GiB window is legal
    localparam logic [32:0] c_LIMIT = 33'd1 << (ROM_AW + 2);

    logic [31:0] w_offset;

    assign w_offset   = i_addr - ROM_BASE;
    // The lower-bound test rejects addresses below the base that would
    // otherwise wrap into a small offset.
    assign o_in_range = (i_addr >= ROM_BASE) && ({1'b0, w_offset} < c_LIMIT);
    assign o_aligned  = (i_addr[1:0] == 2'b00);
    assign o_word_idx = w_offset[ROM_AW+1:2];

endmodule : rom_addr_check
`default_nettype wire

// File: rtl/rom_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_access_ctrl
// Purpose  : Single-port controller in front of the 4-lane instruction ROM.
//            Shares the ROM between instruction fetch and the boot loader,
//            enforces the boot phase, range/alignment checks, fetch-priority
//            arbitration with loader anti-starvation, and absorbs the ROM's
//            one-cycle read latency.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous reset, ACTIVE-HIGH despite its name
//            bus   - rom_access_ctrl_if.slave (fetch, loader and ROM ports)
// Revision : 1.0 - initial release
// ============================================================================
module rom_access_ctrl
    import rom_access_ctrl_pkg::*;
#(
    parameter int          ROM_AW        = ROM_AW_DEF,
    parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
    parameter int          MAX_FETCH_RUN = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rom_access_ctrl_if.slave   bus
);
    localparam int c_CNT_W = $clog2(MAX_FETCH_RUN + 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [c_CNT_W-1:0] r_run_cnt;
    logic               r_resp_vld;
    logic               r_resp_err;

    logic               w_f_in_range, w_f_aligned;
    logic [ROM_AW-1:0]  w_f_idx;
    logic               w_l_in_range, w_unused_l_aligned;
    logic [ROM_AW-1:0]  w_l_idx;

    logic               w_force_load;
    logic               w_fetch_gnt;
    logic               w_load_gnt;
    logic               w_fetch_rd;
    logic               w_load_wr;

    rom_addr_check #(.ROM_AW(ROM_AW), .ROM_BASE(ROM_BASE)) u_fetch_chk (
        .i_addr     (bus.fetch_addr_i),
        .o_in_range (w_f_in_range),
        .o_aligned  (w_f_aligned),
        .o_word_idx (w_f_idx)
    );

    // Loader address bits [1:0] are don't-care, so its alignment is unused
    rom_addr_check #(.ROM_AW(ROM_AW), .ROM_BASE(ROM_BASE)) u_load_chk (
        .i_addr     (bus.load_addr_i),
        .o_in_range (w_l_in_range),
        .o_aligned  (w_unused_l_aligned),
        .o_word_idx (w_l_idx)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= ST_BOOT;
        else       r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Arbitration and next state
    // ------------------------------------------------------------------
    always_comb begin
        w_force_load = 1'b0;
        w_fetch_gnt  = 1'b0;
        w_load_gnt   = 1'b0;
        w_state_nxt  = r_state;
        if (!rst_n) begin
            if (r_state == ST_BOOT) begin
                // Boot-time fetches never reach the ROM, so both requesters
                // can be answered in the same cycle.
                w_fetch_gnt = bus.fetch_req_i;
                w_load_gnt  = bus.load_req_i;
                if (bus.load_req_i && bus.load_last_i)
                    w_state_nxt = ST_RUN;
            end else begin
                w_force_load = bus.load_req_i &&
                               (r_run_cnt >= c_CNT_W'(MAX_FETCH_RUN));
                w_fetch_gnt  = bus.fetch_req_i && !w_force_load;
                w_load_gnt   = bus.load_req_i && (!bus.fetch_req_i || w_force_load);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_rd      = w_fetch_gnt && (r_state == ST_RUN) && w_f_aligned && w_f_in_range;
        w_load_wr       = w_load_gnt && w_l_in_range;
        bus.fetch_gnt_o = w_fetch_gnt;
        bus.load_ack_o  = w_load_gnt;
        bus.rom_re_o    = w_fetch_rd;
        bus.rom_we_o    = w_load_wr ? bus.load_be_i   : 4'h0;
        bus.rom_wdata_o = w_load_wr ? bus.load_data_i : 32'h0;
        bus.rom_addr_o  = w_fetch_rd ? w_f_idx : (w_load_wr ? w_l_idx : '0);
    end

    assign bus.boot_done_o   = (r_state == ST_RUN);
    assign bus.fetch_valid_o = r_resp_vld;
    assign bus.fetch_err_o   = r_resp_err;
    // ROM read data arrives the cycle after rom_re_o, aligned with the response
    assign bus.fetch_data_o  = (r_resp_vld && !r_resp_err) ? bus.rom_rdata_i : 32'h0;

    // ------------------------------------------------------------------
    // Fetch response pipeline and loader anti-starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_resp_vld <= 1'b0;
            r_resp_err <= 1'b0;
            r_run_cnt  <= '0;
        end else begin
            r_resp_vld <= w_fetch_gnt;
            r_resp_err <= w_fetch_gnt && !w_fetch_rd;
            // Counts fetch wins over a waiting load; any served load or an
            // idle loader starts a fresh run.
            if (!bus.load_req_i || w_load_gnt)
                r_run_cnt <= '0;
            else if (w_fetch_gnt)
                r_run_cnt <= r_run_cnt + c_CNT_W'(1);
        end
    end

endmodule : rom_access_ctrl
`default_nettype wire

// File: doc/rom_access_ctrl.md
Name: rom_access_ctrl

Overview:
- Single-port controller in front of the 4-byte-lane instruction ROM. Shares the ROM between the instruction-fetch requester (IF stage) and the boot loader, which writes program words.
- Enforces a boot phase, range/alignment checks, fetch-priority arbitration with anti-starvation for the loader, and the ROM's one-cycle read latency.
- Sits between IF/boot-loader and the ROM array.

Parameters:
ROM_AW, 10, word-address width of the ROM (depth = 2**ROM_AW 32-bit words)
ROM_BASE, 32'h0000_0000, byte base address of the ROM window
MAX_FETCH_RUN, 8, consecutive fetch grants allowed while a load is pending before one load is forced

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1) despite the name
fetch_req_i  input  1  fetch request, held until granted
fetch_addr_i  input  32  fetch byte address
fetch_gnt_o  output  1  fetch accepted this cycle
fetch_valid_o  output  1  fetch response valid
fetch_data_o  output  32  fetched instruction
fetch_err_o  output  1  fetch response is an error (misaligned / out of range / during boot)
load_req_i  input  1  loader write request, held until acked
load_addr_i  input  32  loader byte address
load_data_i  input  32  loader write data
load_be_i  input  4  byte enables; bit3 = [31:24] ... bit0 = [7:0]
load_last_i  input  1  qualifies load_req_i: final boot word
load_ack_o  output  1  loader write accepted (or dropped if out of range)
boot_done_o  output  1  boot phase finished
rom_addr_o  output  ROM_AW  ROM word address
rom_re_o  output  1  ROM read strobe
rom_we_o  output  4  ROM per-lane write strobes
rom_wdata_o  output  32  ROM write data
rom_rdata_i  input  32  ROM read data, valid the cycle after rom_re_o

Behaviour:
- Reset (async, active-high): all outputs 0; boot_done_o = 0; run counter = 0; state = BOOT.
- States:
  - BOOT: only loads are served. A fetch_req_i is granted immediately, with a response of fetch_valid_o = 1 and fetch_err_o = 1 one cycle later; the ROM is not accessed.
  - BOOT -> RUN: on the cycle a load with load_last_i = 1 is acked; boot_done_o = 1 from the next cycle. RUN is permanent until reset.
- RUN arbitration, one grant per cycle:
  - Fetch wins by default.
  - Run counter increments on each fetch grant while load_req_i = 1.
  - When the counter reaches MAX_FETCH_RUN and a load is pending, the load wins that cycle and the counter clears.
  - The counter also clears on any cycle with load_req_i = 0.
- Address check, both requesters: word index = (addr - ROM_BASE) >> 2. In range iff ROM_BASE <= addr < ROM_BASE + 4*2**ROM_DEPTH-words (i.e. addr - ROM_BASE < 2**(ROM_AW+2)). Unsigned 32-bit compare; no wrap.
- Fetch grant, cycle N:
  - fetch_gnt_o = 1 (combinational).
  - If aligned (addr[1:0] = 0) and in range: rom_re_o = 1, rom_addr_o = word index. In N+1: fetch_valid_o = 1, fetch_data_o = rom_rdata_i, fetch_err_o = 0.
  - Otherwise: no ROM access. In N+1: fetch_valid_o = 1, fetch_err_o = 1, fetch_data_o = 0.
- Load grant, cycle N:
  - load_ack_o = 1 (combinational).
  - If in range: rom_we_o = load_be_i, rom_wdata_o = load_data_i, rom_addr_o = word index.
  - Out of range: acked, nothing written. The write is otherwise silently dropped; load_last_i still ends BOOT.
  - load_addr_i[1:0] is ignored.
- Only one of rom_re_o / rom_we_o is non-zero per cycle. rom_* outputs are 0 when nothing is granted.
- Throughput: one fetch per cycle, back-to-back. fetch_valid_o is a 1-cycle pulse per grant; there is no response backpressure.
- Reset mid-operation: an in-flight response is discarded, so fetch_valid_o is 0 from reset assertion. BOOT is re-entered.

Decomposition:
- Shared header: state encodings (ST_BOOT, ST_RUN), ROM_AW default, byte-lane index constants.
- One natural sub-module, rom_addr_check: combinational range/alignment decoder, instantiated twice (fetch, load).

Test Plan:
1. Reset, then fetch_req_i = 1 at 0x0 before boot -> fetch_gnt_o = 1, next cycle fetch_valid_o = 1, fetch_err_o = 1, rom_re_o never 1.
2. Load 0x0 = 0xDEAD_BEEF (be = 4'hF), then 0x4 = 0x1234_5678 (be = 4'b0011, last = 1) -> rom_we_o = F then 3; boot_done_o = 1 the cycle after the second ack.
3. Back-to-back fetches 0x0, 0x4 after boot -> rom_re_o on 2 consecutive cycles; fetch_data_o = 0xDEADBEEF, then the ROM word at index 1, each one cycle after its grant.
4. Fetch held continuously with a load pending, MAX_FETCH_RUN = 8 -> exactly 8 fetch grants, then 1 load_ack_o with fetch_gnt_o = 0 that cycle, then fetches resume.
5. Fetch 0x2 and fetch ROM_BASE + 4*2**ROM_AW -> both return fetch_err_o = 1 with no ROM access; an out-of-range load is acked with rom_we_o = 0.
6. Assert rst_n while a fetch response is pending -> fetch_valid_o = 0 in that cycle, boot_done_o = 0, and fetches error again until the next load_last_i.
